// File: rtl/mem_bus_pkg.sv
// Shared address map, UART status bit positions and UART FSM encodings for mem_bus.
// Decode helper maps a byte address onto a target select.
package mem_bus_pkg;

    localparam logic [15:0] RAM_BASE       = 16'h0000;
    localparam logic [15:0] RAM_LIMIT      = 16'h7FFF;
    localparam logic [15:0] UART_DATA_ADDR = 16'h8000;
    localparam logic [15:0] UART_STAT_ADDR = 16'h8004;
    localparam logic [15:0] CYCLES_ADDR    = 16'h8008;
    localparam logic [15:0] LED_ADDR       = 16'h800C;

    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_OVF_BIT   = 2;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_UART_DATA,
        SEL_UART_STAT,
        SEL_CYCLES,
        SEL_LED
    } sel_e;

    // Register decode uses the word index only; RAM beyond ram_words decodes to nothing.
    function automatic sel_e decode_addr(input logic [15:0] addr, input logic [13:0] ram_words);
        sel_e sel;
        sel = SEL_NONE;
        if ((addr & ~RAM_LIMIT) == RAM_BASE) begin
            if ({1'b0, addr[14:2]} < ram_words)
                sel = SEL_RAM;
        end else begin
            case (addr[15:2])
                UART_DATA_ADDR[15:2]: sel = SEL_UART_DATA;
                UART_STAT_ADDR[15:2]: sel = SEL_UART_STAT;
                CYCLES_ADDR[15:2]:    sel = SEL_CYCLES;
                LED_ADDR[15:2]:       sel = SEL_LED;
                default:              sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_bus_uart_tx.sv
// UART transmit path: byte FIFO with sticky overflow flag feeding an 8N1 serializer.
// Frames go back-to-back with no idle gap while the FIFO holds data.
module mem_bus_uart_tx
    import mem_bus_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    input  logic       overflow_clr,
    output logic       overflow,
    output logic       tx
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    logic [7:0]        r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_overflow;

    uart_state_e       r_state;
    uart_state_e       w_state_nxt;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic              r_tx;
    logic              w_tx_nxt;

    logic              w_pop;
    logic              w_push_ok;
    logic              w_nonempty;
    logic              w_baud_end;

    assign w_nonempty = (r_count != '0);
    assign w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    // A full FIFO still accepts a push in the same cycle the serializer pops.
    assign w_push_ok  = push && (!full || w_pop);

    assign full     = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty    = !w_nonempty && (r_state == UART_IDLE);
    assign overflow = r_overflow;
    assign tx       = r_tx;

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_fifo[r_wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (overflow_clr)
                r_overflow <= 1'b0;
            else if (push && !w_push_ok)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= UART_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        case (r_state)
            UART_IDLE: begin
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = r_fifo[r_rd_ptr];
                    w_state_nxt = UART_START;
                end
            end
            UART_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = UART_DATA;
                end
            end
            UART_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == 3'd7) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = UART_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            UART_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    w_bit_nxt  = '0;
                    if (w_nonempty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = r_fifo[r_rd_ptr];
                        w_state_nxt = UART_START;
                    end else begin
                        w_state_nxt = UART_IDLE;
                    end
                end
            end
            default: w_state_nxt = UART_IDLE;
        endcase
    end

    // The line level is registered from the next state so tx stays glitch-free.
    always_comb begin
        w_tx_nxt = 1'b1;
        if (w_state_nxt == UART_START)
            w_tx_nxt = 1'b0;
        else if (w_state_nxt == UART_DATA)
            w_tx_nxt = w_shift_nxt[0];
    end

endmodule

// File: rtl/mem_bus.sv
// CPU memory-port slave: word RAM, UART TX, LED register and cycle counter, one-cycle read latency.
// Define MEM_BUS_CYCLES_EN to build the cycle counter; otherwise CYCLES reads 0.
module mem_bus
    import mem_bus_pkg::*;
#(
    parameter int RAM_WORDS    = 4096,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ren,
    input  logic [15:0] addr,
    output logic [31:0] rdata,
    output logic        rd_valid,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    output logic        uart_tx,
    output logic [7:0]  led
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    sel_e              w_sel;
    logic              w_rd;
    logic [3:0]        w_be;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [31:0]       w_cycles;
    logic [31:0]       w_stat;
    logic [31:0]       w_reg_data;
    logic              w_full;
    logic              w_empty;
    logic              w_overflow;
    logic              w_push;
    logic              w_ovf_clr;

    logic [31:0]       r_ram [RAM_WORDS];
    logic [31:0]       r_ram_q;
    logic [31:0]       r_reg_q;
    logic              r_rd_ram;
    logic              r_rd_valid;
    logic [7:0]        r_led;

    assign w_sel     = decode_addr(addr, 14'(RAM_WORDS));
    // A write wins over a simultaneous read; the read is dropped.
    assign w_rd      = ren && !wen;
    assign w_be      = {wmask[0], wmask[1], wmask[2], wmask[3]};
    assign w_ram_idx = addr[RAM_AW+1:2];
    assign w_push    = wen && (w_sel == SEL_UART_DATA) && w_be[0];
    assign w_ovf_clr = wen && (w_sel == SEL_UART_STAT);

    // NOTE: RAM contents are deliberately not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wen && (w_sel == SEL_RAM)) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i])
                    r_ram[w_ram_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (w_rd)
            r_ram_q <= r_ram[w_ram_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_led <= '0;
        else if (wen && (w_sel == SEL_LED) && w_be[0])
            r_led <= wdata[7:0];
    end

`ifdef MEM_BUS_CYCLES_EN
    logic [31:0] r_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cycles <= '0;
        else
            r_cycles <= r_cycles + 32'd1;
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = '0;
`endif

    mem_bus_uart_tx #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (w_push),
        .din          (wdata[7:0]),
        .full         (w_full),
        .empty        (w_empty),
        .overflow_clr (w_ovf_clr),
        .overflow     (w_overflow),
        .tx           (uart_tx)
    );

    always_comb begin
        w_stat                 = '0;
        w_stat[STAT_FULL_BIT]  = w_full;
        w_stat[STAT_EMPTY_BIT] = w_empty;
        w_stat[STAT_OVF_BIT]   = w_overflow;
    end

    always_comb begin
        w_reg_data = '0;
        case (w_sel)
            SEL_UART_STAT: w_reg_data = w_stat;
            SEL_CYCLES:    w_reg_data = w_cycles;
            SEL_LED:       w_reg_data = {24'b0, r_led};
            default:       w_reg_data = '0;
        endcase
    end

    // Both result registers only move on a read, so rdata holds until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_ram   <= 1'b0;
            r_reg_q    <= '0;
        end else begin
            r_rd_valid <= w_rd;
            if (w_rd) begin
                r_rd_ram <= (w_sel == SEL_RAM);
                r_reg_q  <= w_reg_data;
            end
        end
    end

    assign rdata    = r_rd_ram ? r_ram_q : r_reg_q;
    assign rd_valid = r_rd_valid;
    assign led      = r_led;

endmodule

// File: tb/tb_mem_bus.sv
// Scoreboard bench for mem_bus: reads and UART frames are queued at issue and checked by monitors.
// Honours MEM_BUS_CYCLES_EN for the expected CYCLES values.
`timescale 1ns/1ps
module tb_mem_bus;

    localparam int CPB = 4;
    localparam int FD  = 8;
    localparam int RW  = 4096;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        uart_tx;
    logic [7:0]  led;

    mem_bus #(
        .RAM_WORDS    (RW),
        .FIFO_DEPTH   (FD),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ren      (ren),
        .addr     (addr),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .wen      (wen),
        .wdata    (wdata),
        .wmask    (wmask),
        .uart_tx  (uart_tx),
        .led      (led)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          tb_edge = 0;
    logic [31:0] tb_cyc = '0;

    logic [31:0] rd_data_q[$];
    string       rd_name_q[$];
    int          rd_edge_q[$];
    logic [7:0]  tx_q[$];

    always @(posedge clk) tb_edge <= tb_edge + 1;

    // Reference cycle counter: cleared by reset, +1 per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cyc();
`ifdef MEM_BUS_CYCLES_EN
        return tb_cyc;
`else
        return 32'd0;
`endif
    endfunction

    task automatic op(input logic r, input logic w, input logic [15:0] a,
                      input logic [31:0] d, input logic [3:0] m);
        ren = r; wen = w; addr = a; wdata = d; wmask = m;
        @(posedge clk); #1;
        ren = 1'b0; wen = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] m);
        op(1'b0, 1'b1, a, d, m);
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] exp, input string name);
        rd_data_q.push_back(exp);
        rd_name_q.push_back(name);
        rd_edge_q.push_back(tb_edge + 1);
        op(1'b1, 1'b0, a, 32'd0, 4'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_uart_drain(input int budget, input string name);
        int k;
        k = 0;
        while (tx_q.size() != 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check(name, 32'(tx_q.size()), 32'd0);
    endtask

    // Read monitor: every rd_valid pulse must match the oldest queued read, one cycle after issue.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (rd_data_q.size() == 0) begin
                check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
            end else begin
                logic [31:0] exp_d;
                string       nm;
                int          exp_e;
                exp_d = rd_data_q.pop_front();
                nm    = rd_name_q.pop_front();
                exp_e = rd_edge_q.pop_front();
                check(nm, rdata, exp_d);
                check({nm, "_latency"}, 32'(tb_edge), 32'(exp_e));
            end
        end
    end

    // UART monitor: samples every clock of a frame, checks levels, bit widths and the byte.
    initial begin : uart_mon
        logic       prev;
        logic [9:0] bits;
        logic       stable;
        logic       aborted;
        logic [7:0] exp_b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !uart_tx) begin
                bits    = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int b = 0; b < 10 && !aborted; b++) begin
                    for (int s = 0; s < CPB && !aborted; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (!rst_n)             aborted = 1'b1;
                        else if (s == 0)        bits[b] = uart_tx;
                        else if (uart_tx !== bits[b]) stable = 1'b0;
                    end
                end
                if (aborted) begin
                    wait (rst_n);
                end else if (tx_q.size() == 0) begin
                    check("uart_unexpected_frame", 32'(bits), 32'd0);
                end else begin
                    exp_b = tx_q.pop_front();
                    check("uart_frame_bits", 32'(bits), 32'({1'b1, exp_b, 1'b0}));
                    check("uart_bit_timing", 32'(stable), 32'd1);
                end
            end
            prev = uart_tx;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        #1;
        check("reset_uart_tx", 32'(uart_tx), 32'd1);
        check("reset_led", 32'(led), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // RAM byte/half lanes
        wr(16'h0000, 32'h0000_0000, 4'b1111);
        wr(16'h0010, 32'h1122_3344, 4'b1111);
        wr(16'h0010, 32'h0000_AA00, 4'b0100);
        rd(16'h0010, 32'h1122_AA44, "t1_lane1_write");
        idle(2);
        wr(16'h0010, 32'h0000_5566, 4'b1100);
        rd(16'h0010, 32'h1122_5566, "t1_half_write");

        // Read-after-write, back-to-back
        wr(16'h0004, 32'hDEAD_BEEF, 4'b1111);
        rd(16'h0004, 32'hDEAD_BEEF, "t2_read_after_write");
        rd(16'h0000, 32'h0000_0000, "t2_back_to_back");
        idle(1);

        // ren and wen together: write happens, no read response
        op(1'b1, 1'b1, 16'h0020, 32'hCAFE_F00D, 4'b1111);
        rd(16'h0020, 32'hCAFE_F00D, "rw_both_write_done");

        // Map edges
        rd(16'h8010, 32'd0, "t6_unmapped_reg");
        rd(16'h4000, 32'd0, "t6_beyond_ram");
        wr(16'h4000, 32'hFFFF_FFFF, 4'b1111);
        rd(16'h0000, 32'd0, "t6_no_alias_write");
        rd(16'h8000, 32'd0, "uart_data_reads_zero");

        // Counter, two reads five cycles apart
        rd(16'h8008, exp_cyc(), "t6_cycles_a");
        idle(4);
        rd(16'h8008, exp_cyc(), "t6_cycles_b");
        wr(16'h8008, 32'h1234_5678, 4'b1111);
        rd(16'h8008, exp_cyc(), "t6_cycles_write_ignored");

        // LED
        wr(16'h800C, 32'h0000_00A5, 4'b1000);
        check("t6_led_port", 32'(led), 32'h0000_00A5);
        wr(16'h800C, 32'h0000_00FF, 4'b0100);
        check("t6_led_lane0_only", 32'(led), 32'h0000_00A5);
        rd(16'h800C, 32'h0000_00A5, "t6_led_read");

        // UART single byte; lane0 disabled must not push
        wr(16'h8000, 32'h0000_0077, 4'b0111);
        tx_q.push_back(8'h55);
        wr(16'h8000, 32'h0000_0055, 4'b1000);
        wait_uart_drain(200, "t3_frame_done");
        idle(3);
        rd(16'h8004, 32'b010, "t3_stat_idle");

        // Overflow: one byte goes straight to the shifter, 8 fill the FIFO, the 10th is dropped
        for (int i = 0; i < 10; i++) begin
            if (i < 9) tx_q.push_back(8'(8'hA0 + i));
            wr(16'h8000, 32'(8'hA0 + i), 4'b1000);
        end
        rd(16'h8004, 32'b101, "t4_stat_full_ovf");
        wr(16'h8004, 32'd0, 4'b1111);
        rd(16'h8004, 32'b001, "t4_stat_ovf_cleared");
        wait_uart_drain(9 * 10 * CPB + 100, "t4_frames_done");
        idle(3);
        rd(16'h8004, 32'b010, "t4_stat_drained");

        // Async reset during DATA bit 3 of 0xC3 (bit3 = 0)
        idle(2);
        wr(16'h800C, 32'h0000_005A, 4'b1000);
        wr(16'h8000, 32'h0000_00C3, 4'b1000);
        idle(17);
        op(1'b1, 1'b0, 16'h800C, 32'd0, 4'd0);
        check("t5_pre_reset_tx_bit3", 32'(uart_tx), 32'd0);
        check("t5_pre_reset_rd_valid", 32'(rd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_reset_uart_tx", 32'(uart_tx), 32'd1);
        check("t5_reset_led", 32'(led), 32'd0);
        check("t5_reset_rd_valid", 32'(rd_valid), 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        rd(16'h8004, 32'b010, "t5_stat_after_reset");
        rd(16'h800C, 32'd0, "t5_led_after_reset");
        rd(16'h8008, exp_cyc(), "t5_cycles_after_reset");

        idle(8 * CPB);
        check("reads_all_returned", 32'(rd_data_q.size()), 32'd0);
        check("uart_all_sent", 32'(tx_q.size()), 32'd0);
        check("uart_idle_at_end", 32'(uart_tx), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
